msg_stream_seq: RTL and testbench

- Parametrised ASCII message sequencer. Streams one of NUM_MSG stored text messages, one character per transfer.
- Sits between the board control logic (select switches, enable) and the character/display sink.
- Next generation of the team's fixed-string sequencer. Adds a parametrised message table, a valid/ready handshake, loop and one-shot modes, message-boundary-safe selection, framing flags and a completed-message counter.

---
 rtl/msg_pkg.sv | 34 +++
 rtl/msg_stream_seq_if.sv | 28 ++
 rtl/msg_rom.sv | 44 ++++
 rtl/msg_stream_seq.sv | 166 ++++++++++++++++
 tb/tb_msg_stream_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/msg_pkg.sv
// Shared definitions for the message stream sequencer: ASCII constants,
// the default message table and lengths, and the FSM state type.
package msg_pkg;

    localparam int DEF_CHAR_W  = 8;
    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_NUM_MSG = 4;
    localparam int LEN_W       = 8;

    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Rows are left-justified: the first character sits in the top byte.
    localparam logic [DEF_MAX_LEN*DEF_CHAR_W-1:0] MSG_GUATEMALA =
        {"Guatemala", {7{CH_NUL}}};
    localparam logic [DEF_MAX_LEN*DEF_CHAR_W-1:0] MSG_QUETZAL =
        {"Quetzal", {9{CH_NUL}}};
    localparam logic [DEF_MAX_LEN*DEF_CHAR_W-1:0] MSG_ZACAPA =
        {"Zacapa", {10{CH_NUL}}};
    localparam logic [DEF_MAX_LEN*DEF_CHAR_W-1:0] MSG_SOY =
        {"Soy", CH_SPACE, "de", CH_SPACE, "Zacapa", {3{CH_NUL}}};

    localparam logic [DEF_NUM_MSG-1:0][DEF_MAX_LEN-1:0][DEF_CHAR_W-1:0] MSG_TABLE =
        {MSG_SOY, MSG_ZACAPA, MSG_QUETZAL, MSG_GUATEMALA};

    localparam logic [DEF_NUM_MSG-1:0][LEN_W-1:0] MSG_LEN =
        {8'd13, 8'd6, 8'd7, 8'd9};

endpackage

// File: rtl/msg_stream_seq_if.sv
// Character stream link between the sequencer (master) and the display sink.
interface msg_stream_seq_if #(
    parameter int CHAR_W = 8
) ();

    logic [CHAR_W-1:0] q_out;
    logic              valid;
    logic              sof;
    logic              eof;
    logic              ready;

    modport master (
        output q_out,
        output valid,
        output sof,
        output eof,
        input  ready
    );

    modport slave (
        input  q_out,
        input  valid,
        input  sof,
        input  eof,
        output ready
    );

endinterface

// File: rtl/msg_rom.sv
// Combinational message table lookup: (sel, idx) -> character, plus the
// length of the selected message.
module msg_rom
    import msg_pkg::*;
#(
    parameter int CHAR_W  = DEF_CHAR_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int NUM_MSG = DEF_NUM_MSG,
    parameter int SEL_W   = 2,
    parameter int IDX_W   = $clog2(MAX_LEN),
    parameter logic [NUM_MSG-1:0][MAX_LEN-1:0][CHAR_W-1:0] TABLE = msg_pkg::MSG_TABLE,
    parameter logic [NUM_MSG-1:0][LEN_W-1:0] LENGTHS = msg_pkg::MSG_LEN
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [IDX_W-1:0]  idx,
    output logic [CHAR_W-1:0] ch,
    output logic [LEN_W-1:0]  len
);

    // Every stored message must hold between 1 and MAX_LEN characters.
    for (genvar i = 0; i < NUM_MSG; i++) begin : g_len_chk
        if (int'(LENGTHS[i]) == 0 || int'(LENGTHS[i]) > MAX_LEN) begin : g_bad_len
            $error("msg_rom: message %0d has illegal length %0d", i, LENGTHS[i]);
        end
    end

    logic [MAX_LEN-1:0][CHAR_W-1:0] row;
    logic [IDX_W-1:0]               rev_idx;

    assign rev_idx = IDX_W'(MAX_LEN - 1) - idx;

    always_comb begin
        row = '0;
        len = '0;
        for (int m = 0; m < NUM_MSG; m++) begin
            if (sel == SEL_W'(m)) begin
                row = TABLE[m];
                len = LENGTHS[m];
            end
        end
        ch = row[rev_idx];
    end

endmodule

// File: rtl/msg_stream_seq.sv
// Parametrised ASCII message sequencer: streams stored messages one character
// per valid/ready transfer, in loop or one-shot mode.
module msg_stream_seq
    import msg_pkg::*;
#(
    parameter int CHAR_W  = DEF_CHAR_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int NUM_MSG = DEF_NUM_MSG,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 8,
    parameter logic [NUM_MSG-1:0][MAX_LEN-1:0][CHAR_W-1:0] TABLE = msg_pkg::MSG_TABLE,
    parameter logic [NUM_MSG-1:0][LEN_W-1:0] LENGTHS = msg_pkg::MSG_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic              start,
    input  logic [SEL_W-1:0]  select,
    msg_stream_seq_if.master  stream,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  active_sel,
    output logic [CNT_W-1:0]  msg_cnt
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [SEL_W:0] NUM_MSG_X = (SEL_W + 1)'(NUM_MSG);

    if ((1 << SEL_W) < NUM_MSG) begin : g_bad_sel_w
        $error("msg_stream_seq: SEL_W=%0d too narrow for NUM_MSG=%0d", SEL_W, NUM_MSG);
    end

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx_r, idx_next;
    logic [CHAR_W-1:0] q_r, q_next;
    logic              valid_r, valid_next;
    logic              sof_r, sof_next;
    logic              eof_r, eof_next;
    logic              done_r, done_next;
    logic [SEL_W-1:0]  sel_r, sel_next;
    logic [CNT_W-1:0]  cnt_r, cnt_next;

    logic              xfer;
    logic              start_new;
    logic              advance;
    logic [SEL_W-1:0]  sel_clamp;
    logic [SEL_W-1:0]  rom_sel;
    logic [IDX_W-1:0]  rom_idx;
    logic [CHAR_W-1:0] rom_ch;
    logic [LEN_W-1:0]  rom_len;
    logic              rom_last;

    assign xfer      = valid_r & stream.ready;
    assign sel_clamp = ({1'b0, select} < NUM_MSG_X) ? select : '0;

    // A new message begins either from IDLE or back-to-back after a final
    // transfer in loop mode; otherwise a transfer just steps to the next char.
    always_comb begin
        start_new = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE:    start_new = en & (~mode | start);
            STREAM: begin
                start_new = xfer & eof_r & ~mode & en;
                advance   = xfer & ~eof_r;
            end
            default: start_new = 1'b0;
        endcase
    end

    // The ROM always looks up the character that will be shown next.
    assign rom_sel  = start_new ? sel_clamp : sel_r;
    assign rom_idx  = start_new ? '0 : idx_r + IDX_W'(1);
    assign rom_last = (rom_idx == IDX_W'(rom_len - LEN_W'(1)));

    msg_rom #(
        .CHAR_W  (CHAR_W),
        .MAX_LEN (MAX_LEN),
        .NUM_MSG (NUM_MSG),
        .SEL_W   (SEL_W),
        .IDX_W   (IDX_W),
        .TABLE   (TABLE),
        .LENGTHS (LENGTHS)
    ) u_rom (
        .sel (rom_sel),
        .idx (rom_idx),
        .ch  (rom_ch),
        .len (rom_len)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx_r;
        q_next     = q_r;
        valid_next = valid_r;
        sof_next   = sof_r;
        eof_next   = eof_r;
        sel_next   = sel_r;
        cnt_next   = cnt_r;
        done_next  = 1'b0;

        if (state == STREAM && xfer && eof_r) begin
            cnt_next = cnt_r + CNT_W'(1);
            if (!start_new) begin
                state_next = IDLE;
                valid_next = 1'b0;
                sof_next   = 1'b0;
                eof_next   = 1'b0;
                q_next     = '0;
                done_next  = mode;
            end
        end

        if (advance) begin
            idx_next = rom_idx;
            q_next   = rom_ch;
            sof_next = 1'b0;
            eof_next = rom_last;
        end

        if (start_new) begin
            state_next = STREAM;
            sel_next   = sel_clamp;
            idx_next   = '0;
            q_next     = rom_ch;
            valid_next = 1'b1;
            sof_next   = 1'b1;
            eof_next   = rom_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx_r   <= '0;
            q_r     <= '0;
            valid_r <= 1'b0;
            sof_r   <= 1'b0;
            eof_r   <= 1'b0;
            done_r  <= 1'b0;
            sel_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state   <= state_next;
            idx_r   <= idx_next;
            q_r     <= q_next;
            valid_r <= valid_next;
            sof_r   <= sof_next;
            eof_r   <= eof_next;
            done_r  <= done_next;
            sel_r   <= sel_next;
            cnt_r   <= cnt_next;
        end
    end

    assign stream.q_out = q_r;
    assign stream.valid = valid_r;
    assign stream.sof   = sof_r;
    assign stream.eof   = eof_r;
    assign busy         = (state == STREAM);
    assign done         = done_r;
    assign active_sel   = sel_r;
    assign msg_cnt      = cnt_r;

endmodule

// File: tb/tb_msg_stream_seq.sv
// Directed bench for msg_stream_seq with hand-written expected character
// streams; counter width shrunk to 2 bits so the wrap is reachable.
module tb_msg_stream_seq;

    localparam int CHAR_W = 8;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             start = 1'b0;
    logic [SEL_W-1:0] select = '0;
    logic             busy;
    logic             done;
    logic [SEL_W-1:0] active_sel;
    logic [CNT_W-1:0] msg_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_msg [4][13] = '{
        '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h5A, 8'h61, 8'h63, 8'h61, 8'h70, 8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h53, 8'h6F, 8'h79, 8'h20, 8'h64, 8'h65, 8'h20, 8'h5A, 8'h61, 8'h63, 8'h61, 8'h70, 8'h61}
    };
    int exp_len [4] = '{9, 7, 6, 13};

    msg_stream_seq_if #(.CHAR_W(CHAR_W)) stream_bus ();

    msg_stream_seq #(
        .CHAR_W  (CHAR_W),
        .MAX_LEN (16),
        .NUM_MSG (4),
        .SEL_W   (SEL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .start      (start),
        .select     (select),
        .stream     (stream_bus),
        .busy       (busy),
        .done       (done),
        .active_sel (active_sel),
        .msg_cnt    (msg_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic m, input logic s,
                                 input logic [SEL_W-1:0] sel, input logic r);
        en              = e;
        mode            = m;
        start           = s;
        select          = sel;
        stream_bus.ready = r;
    endtask

    // Streams message m with ready held high, checking every character; an
    // optional hook changes select and/or pulses start mid-message.
    task automatic streamMsg(input int m, input int sel_exp, input int cnt_exp,
                             input int hook_at, input int new_sel, input bit start_pulse);
        for (int k = 0; k < exp_len[m]; k++) begin
            if (k == hook_at) begin
                select = SEL_W'(new_sel);
                start  = start_pulse;
            end
            if (k == hook_at + 1) start = 1'b0;
            checkOutput($sformatf("m%0d_q%0d", m, k), 32'(stream_bus.q_out), 32'(exp_msg[m][k]));
            checkOutput($sformatf("m%0d_sof%0d", m, k), 32'(stream_bus.sof), 32'(k == 0));
            checkOutput($sformatf("m%0d_eof%0d", m, k), 32'(stream_bus.eof), 32'(k == exp_len[m] - 1));
            checkOutput($sformatf("m%0d_valid%0d", m, k), 32'(stream_bus.valid), 32'd1);
            checkOutput($sformatf("m%0d_sel%0d", m, k), 32'(active_sel), 32'(sel_exp));
            step();
        end
        checkOutput($sformatf("m%0d_msg_cnt", m), 32'(msg_cnt), 32'(cnt_exp));
    endtask

    initial begin
        int   pos;
        int   cyc;
        logic rdy;

        $display("[TB] starting msg_stream_seq bench");
        stream_bus.ready = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (5) step();
        checkOutput("rst_q", 32'(stream_bus.q_out), 32'd0);
        checkOutput("rst_valid", 32'(stream_bus.valid), 32'd0);
        checkOutput("rst_sof", 32'(stream_bus.sof), 32'd0);
        checkOutput("rst_eof", 32'(stream_bus.eof), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sel", 32'(active_sel), 32'd0);
        checkOutput("rst_cnt", 32'(msg_cnt), 32'd0);

        // Loop mode, then a select change mid-message taking effect next message
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        step();
        checkOutput("loop_busy", 32'(busy), 32'd1);
        streamMsg(0, 0, 1, -1, 0, 1'b0);
        streamMsg(0, 0, 2, 2, 1, 1'b0);
        streamMsg(1, 1, 3, -1, 1, 1'b0);

        // en dropped at the start of a message: it still completes, count wraps
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
        streamMsg(1, 1, 0, -1, 1, 1'b0);
        checkOutput("endrop_valid", 32'(stream_bus.valid), 32'd0);
        checkOutput("endrop_busy", 32'(busy), 32'd0);
        checkOutput("endrop_done", 32'(done), 32'd0);

        // Random backpressure on "Zacapa", two messages then en drop
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        step();
        pos = 0;
        cyc = 0;
        checkOutput("bp_first_q", 32'(stream_bus.q_out), 32'h5A);
        checkOutput("bp_first_sof", 32'(stream_bus.sof), 32'd1);
        while (pos < 12 && cyc < 300) begin
            rdy = 1'($urandom_range(0, 1));
            stream_bus.ready = rdy;
            step();
            cyc++;
            if (rdy) pos++;
            if (pos == 7) en = 1'b0;
            if (pos < 12) begin
                checkOutput($sformatf("bp_q_p%0d", pos), 32'(stream_bus.q_out), 32'(exp_msg[2][pos % 6]));
                checkOutput($sformatf("bp_sof_p%0d", pos), 32'(stream_bus.sof), 32'(pos % 6 == 0));
                checkOutput($sformatf("bp_eof_p%0d", pos), 32'(stream_bus.eof), 32'(pos % 6 == 5));
                checkOutput($sformatf("bp_valid_p%0d", pos), 32'(stream_bus.valid), 32'd1);
                checkOutput($sformatf("bp_sel_p%0d", pos), 32'(active_sel), 32'd2);
            end
        end
        checkOutput("bp_chars", 32'(pos), 32'd12);
        checkOutput("bp_end_valid", 32'(stream_bus.valid), 32'd0);
        checkOutput("bp_end_cnt", 32'(msg_cnt), 32'd2);

        // One-shot with a second start inside STREAM that must be ignored
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
        step();
        start = 1'b0;
        streamMsg(3, 3, 3, 4, 3, 1'b1);
        checkOutput("os_done", 32'(done), 32'd1);
        checkOutput("os_valid", 32'(stream_bus.valid), 32'd0);
        checkOutput("os_busy", 32'(busy), 32'd0);
        step();
        checkOutput("os_done_clr", 32'(done), 32'd0);
        checkOutput("os_valid_idle", 32'(stream_bus.valid), 32'd0);
        checkOutput("os_busy_idle", 32'(busy), 32'd0);
        checkOutput("os_cnt_idle", 32'(msg_cnt), 32'd3);

        // Asynchronous reset in the middle of a message
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
        repeat (3) step();
        checkOutput("ar_pre_q", 32'(stream_bus.q_out), 32'h65);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("ar_q", 32'(stream_bus.q_out), 32'd0);
        checkOutput("ar_valid", 32'(stream_bus.valid), 32'd0);
        checkOutput("ar_sof", 32'(stream_bus.sof), 32'd0);
        checkOutput("ar_busy", 32'(busy), 32'd0);
        checkOutput("ar_sel", 32'(active_sel), 32'd0);
        checkOutput("ar_cnt", 32'(msg_cnt), 32'd0);
        step();
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
